// File: rtl/i2c_reg_target.sv
// rtl/i2c_reg_target.sv - I2C target with register-pointer protocol
//
// Oversamples SCL/SDA on clk, answers bus address SLV_ADDR and exposes an
// external byte register bank through a pointer.
//   clk, reset : system clock, synchronous active-high reset
//   SCL        : bus clock from the master (input only, never stretched)
//   SDA        : open-drain bus data, driven 0 or released
//   wr_en      : one-clk strobe carrying wr_addr/wr_data into the bank
//   rd_addr    : current pointer; rd_data is the bank byte at that index
//   busy       : set on a matched address, cleared on STOP or IDLE

module i2c_reg_target #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         PTR_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SCL,
    inout  logic             SDA,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_ADDR,
        S_PTR,
        S_ACK_PTR,
        S_WDATA,
        S_ACK_WDATA,
        S_RDATA,
        S_RACK,
        S_IGNORE
    } state_t;

    state_t           state;
    logic [3:0]       bit_cnt;
    logic [6:0]       rx_sr;
    logic [6:0]       tx_sr;
    logic             rw;
    logic [PTR_W-1:0] ptr;
    logic             sda_oe;

    logic scl_s1, scl_s2, scl_prev;
    logic sda_s1, sda_s2, sda_prev;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det;
    logic [7:0] rx_byte;

    // Synchronizers reset to the idle-bus level so leaving reset never
    // fabricates an edge on a quiet bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_prev <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_s1   <= SCL;
            scl_s2   <= scl_s1;
            scl_prev <= scl_s2;
            sda_s1   <= SDA;
            sda_s2   <= sda_s1;
            sda_prev <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_prev;
    assign scl_fall  = ~scl_s2 & scl_prev;
    assign sda_rise  = sda_s2 & ~sda_prev;
    assign sda_fall  = ~sda_s2 & sda_prev;
    assign start_det = sda_fall & scl_s2;
    assign stop_det  = sda_rise & scl_s2;

    // Byte completed by the bit being sampled on this scl_rise.
    assign rx_byte = {rx_sr, sda_s2};

    assign rd_addr = ptr;

    // Reset gates the driver directly so SDA lets go in the reset cycle.
    assign SDA = (sda_oe && !reset) ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= 4'd0;
            rx_sr   <= 7'd0;
            tx_sr   <= 7'd0;
            rw      <= 1'b0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'd0;
            busy    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= S_IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end

                    S_ADDR: begin
                        if (scl_rise) begin
                            rx_sr <= {rx_sr[5:0], sda_s2};
                            if (bit_cnt == 4'd7) begin
                                // rx_sr already holds the 7 address bits;
                                // the bit on the wire now is R/W.
                                bit_cnt <= 4'd0;
                                rw      <= sda_s2;
                                if (rx_sr == SLV_ADDR) begin
                                    state <= S_ACK_ADDR;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= S_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // ACK phases: bit_cnt 0 until the 9th rise, 1 after it.
                    // The first fall asserts the ACK, the fall after the
                    // 9th rise ends it.
                    S_ACK_ADDR: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt <= 4'd0;
                                if (rw) begin
                                    state  <= S_RDATA;
                                    tx_sr  <= rd_data[6:0];
                                    sda_oe <= ~rd_data[7];
                                end else begin
                                    state  <= S_PTR;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end

                    S_PTR: begin
                        if (scl_rise) begin
                            rx_sr <= {rx_sr[5:0], sda_s2};
                            if (bit_cnt == 4'd7) begin
                                ptr     <= rx_byte[PTR_W-1:0];
                                state   <= S_ACK_PTR;
                                bit_cnt <= 4'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_ACK_PTR, S_ACK_WDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b0;
                                state   <= S_WDATA;
                            end
                        end
                    end

                    S_WDATA: begin
                        if (scl_rise) begin
                            rx_sr <= {rx_sr[5:0], sda_s2};
                            if (bit_cnt == 4'd7) begin
                                wr_data <= rx_byte;
                                wr_addr <= ptr;
                                wr_en   <= 1'b1;
                                ptr     <= ptr + 1'b1;
                                state   <= S_ACK_WDATA;
                                bit_cnt <= 4'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // bit_cnt counts bits the master has sampled; the fall
                    // after the 8th hands SDA back for the master's ACK.
                    S_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                state   <= S_RACK;
                                bit_cnt <= 4'd0;
                            end else begin
                                sda_oe <= ~tx_sr[6];
                                tx_sr  <= {tx_sr[5:0], 1'b0};
                            end
                        end
                    end

                    // The pointer moves on the ACK rise so rd_data already
                    // shows the next byte when it is loaded on the fall.
                    S_RACK: begin
                        if (scl_rise) begin
                            if (!sda_s2) begin
                                ptr     <= ptr + 1'b1;
                                bit_cnt <= 4'd1;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state   <= S_RDATA;
                            bit_cnt <= 4'd0;
                            tx_sr   <= rd_data[6:0];
                            sda_oe  <= ~rd_data[7];
                        end
                    end

                    S_IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        state  <= S_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// tb/tb_i2c_reg_target.sv - directed bench for i2c_reg_target with model scoreboard

module tb_i2c_reg_target;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_low;
    wire        sda_bus;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    logic [7:0] bank [16];

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    assign rd_data = bank[rd_addr];

    i2c_reg_target #(.SLV_ADDR(7'h50), .PTR_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .SCL     (scl),
        .SDA     (sda_bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: expected write strobes {addr, data}, pointer, quiet-bus flag.
    logic [11:0] exp_wr [$];
    int          m_ptr = 0;
    bit          m_quiet = 1'b0;
    logic        wr_en_q = 1'b0;
    logic [11:0] e_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", {31'd0, wr_en}, 32'd0);
                end else begin
                    e_cur = exp_wr.pop_front();
                    chk("wr_addr", {28'd0, wr_addr}, {28'd0, e_cur[11:8]});
                    chk("wr_data", {24'd0, wr_data}, {24'd0, e_cur[7:0]});
                end
                if (wr_en_q) chk("wr_en_width", {31'd0, wr_en_q}, 32'd0);
            end
            if (m_quiet && !sda_low) chk("sda_quiet", {31'd0, sda_bus}, 32'd1);
        end
        wr_en_q = wr_en;
    end

    task automatic wait_q;
        repeat (5) @(negedge clk);
    endtask

    task automatic bus_start;
        sda_low = 1'b0; wait_q;
        scl = 1'b1;     wait_q;
        sda_low = 1'b1; wait_q;
        scl = 1'b0;     wait_q;
    endtask

    task automatic bus_stop;
        sda_low = 1'b1; wait_q;
        scl = 1'b1;     wait_q;
        sda_low = 1'b0; wait_q;
    endtask

    task automatic put_bit(input logic b);
        sda_low = ~b; wait_q;
        scl = 1'b1;   wait_q; wait_q;
        scl = 1'b0;   wait_q;
    endtask

    task automatic get_bit(output logic b);
        sda_low = 1'b0; wait_q;
        scl = 1'b1;     wait_q;
        b = sda_bus;    wait_q;
        scl = 1'b0;     wait_q;
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(input logic mack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(mack);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] v;
        logic [7:0] t4_data [2];
        logic [7:0] t3_lit [3];
        logic [7:0] t5_addr;

        t4_data[0] = 8'h01; t4_data[1] = 8'h02;
        t3_lit[0] = 8'h5A; t3_lit[1] = 8'hC3; t3_lit[2] = 8'h7E;
        for (int i = 0; i < 16; i++) bank[i] = 8'h00;
        reset = 1'b1; scl = 1'b1; sda_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sda", {31'd0, sda_bus}, 32'd1);
        reset = 1'b0;
        wait_q;

        // Plain write: pointer 3, data 0x11, 0x22.
        bus_start;
        put_byte(8'hA0, ack); chk("t1_addr_ack", {31'd0, ack}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        put_byte(8'h03, ack); chk("t1_ptr_ack", {31'd0, ack}, 32'd0);
        m_ptr = 3;
        chk("t1_ptr", {28'd0, rd_addr}, m_ptr);
        exp_wr.push_back({4'd3, 8'h11});
        put_byte(8'h11, ack); chk("t1_d0_ack", {31'd0, ack}, 32'd0);
        exp_wr.push_back({4'd4, 8'h22});
        put_byte(8'h22, ack); chk("t1_d1_ack", {31'd0, ack}, 32'd0);
        m_ptr = 5;
        bus_stop; wait_q;
        chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        chk("t1_writes_done", exp_wr.size(), 32'd0);
        chk("t1_ptr_end", {28'd0, rd_addr}, m_ptr);

        // Address mismatch 0x51: NACK and silence.
        bus_start;
        m_quiet = 1'b1;
        put_byte(8'hA2, ack); chk("t2_addr_nack", {31'd0, ack}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        put_byte(8'h03, ack); chk("t2_b1_nack", {31'd0, ack}, 32'd1);
        put_byte(8'h55, ack); chk("t2_b2_nack", {31'd0, ack}, 32'd1);
        m_quiet = 1'b0;
        bus_stop; wait_q;
        chk("t2_ptr_kept", {28'd0, rd_addr}, m_ptr);

        // Write pointer 14, repeated START, read three bytes across wrap.
        bank[14] = 8'h5A; bank[15] = 8'hC3; bank[0] = 8'h7E;
        bus_start;
        put_byte(8'hA0, ack); chk("t3_addr_ack", {31'd0, ack}, 32'd0);
        put_byte(8'h0E, ack); chk("t3_ptr_ack", {31'd0, ack}, 32'd0);
        m_ptr = 14;
        chk("t3_ptr", {28'd0, rd_addr}, m_ptr);
        bus_start;
        put_byte(8'hA1, ack); chk("t3_raddr_ack", {31'd0, ack}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            get_byte(k == 2, v);
            chk("t3_rd_model", {24'd0, v}, {24'd0, bank[m_ptr]});
            chk("t3_rd_lit", {24'd0, v}, {24'd0, t3_lit[k]});
            if (k != 2) m_ptr = (m_ptr + 1) % 16;
        end
        chk("t3_sda_released", {31'd0, sda_bus}, 32'd1);
        chk("t3_ptr_end", {28'd0, rd_addr}, m_ptr);
        bus_stop; wait_q;

        // Pointer 15, two writes wrap to 0.
        bus_start;
        put_byte(8'hA0, ack); chk("t4_addr_ack", {31'd0, ack}, 32'd0);
        put_byte(8'h0F, ack); chk("t4_ptr_ack", {31'd0, ack}, 32'd0);
        m_ptr = 15;
        for (int k = 0; k < 2; k++) begin
            exp_wr.push_back({4'(m_ptr % 16), t4_data[k]});
            put_byte(t4_data[k], ack); chk("t4_d_ack", {31'd0, ack}, 32'd0);
            m_ptr = (m_ptr + 1) % 16;
        end
        bus_stop; wait_q;
        chk("t4_writes_done", exp_wr.size(), 32'd0);
        chk("t4_wrap_ptr", {28'd0, rd_addr}, 32'd1);

        // STOP after four data bits: no strobe, bus idle.
        bus_start;
        put_byte(8'hA0, ack); chk("t5_addr_ack", {31'd0, ack}, 32'd0);
        put_byte(8'h05, ack); chk("t5_ptr_ack", {31'd0, ack}, 32'd0);
        m_ptr = 5;
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        bus_stop; wait_q;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_sda", {31'd0, sda_bus}, 32'd1);
        chk("t5_no_write", exp_wr.size(), 32'd0);
        bus_start;
        t5_addr = 8'hA0;
        for (int i = 7; i >= 0; i--) put_bit(t5_addr[i]);
        sda_low = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_ack_low", {31'd0, sda_bus}, 32'd0);
        chk("t5_busy_again", {31'd0, busy}, 32'd1);
        chk("t5_ptr", {28'd0, rd_addr}, m_ptr);

        // Reset while the ACK is being driven.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_sda_same_cycle", {31'd0, sda_bus}, 32'd1);
        @(negedge clk);
        chk("t6_wr_en", {31'd0, wr_en}, 32'd0);
        chk("t6_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("t6_wr_data", {24'd0, wr_data}, 32'd0);
        chk("t6_rd_addr", {28'd0, rd_addr}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_sda", {31'd0, sda_bus}, 32'd1);
        reset = 1'b0;
        m_ptr = 0;
        wait_q;
        bus_stop; wait_q;

        // Read after reset starts at pointer 0.
        bus_start;
        put_byte(8'hA1, ack); chk("t6_raddr_ack", {31'd0, ack}, 32'd0);
        get_byte(1'b1, v);
        chk("t6_rd_model", {24'd0, v}, {24'd0, bank[m_ptr]});
        chk("t6_rd_lit", {24'd0, v}, 32'h7E);
        bus_stop; wait_q;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
- I2C responder (target) with a register-pointer protocol.
- Pairs with i2c_master as the bus partner. Decodes START/STOP, matches its 7-bit address and ACKs it.
- On write: the first data byte loads the register pointer; following bytes become register write strobes.
- On read: the target shifts out register data from an external register bank.
- Oversamples SCL/SDA on the system clock. The bus side is open-drain only: it drives 0 or releases SDA.

Parameters:
- SLV_ADDR, 7'h50, 7-bit bus address the block responds to.
- PTR_W, 4, register pointer width; the bank holds 2**PTR_W bytes.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- SCL  input  1  bus clock (from master)
- SDA  inout  1  bus data; driven 1'b0 or 1'bz only
- wr_en  output  1  one-clk write strobe
- wr_addr  output  PTR_W  write register index
- wr_data  output  8  write register data
- rd_addr  output  PTR_W  read register index (= pointer)
- rd_data  input  8  register contents at rd_addr (combinational from bank)
- busy  output  1  high from a matched address until STOP or return to IDLE

Behaviour:
- Reset values: SDA released (z), wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, pointer=0, busy=0, state=IDLE. Reset mid-transfer releases SDA immediately (same cycle as reset sampled).
- Input conditioning: SCL and SDA each pass through a 2-flop synchronizer plus a previous-value flop. scl_rise, scl_fall, sda_rise and sda_fall are single-clk pulses derived from those flops.
- START: sda_fall while synced SCL=1. STOP: sda_rise while synced SCL=1.
  - START or STOP in any state overrides all other activity.
  - START -> ADDR, bit count cleared, SDA released.
  - STOP -> IDLE, busy=0.
- SDA timing: data is sampled on scl_rise. The target changes SDA only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first (7 address bits + R/W). After bit 8:
    - if addr==SLV_ADDR: go to ACK_ADDR, busy=1;
    - else: go to IGNORE (SDA stays released until the next START or STOP).
  - ACK_ADDR: drive SDA=0 from the scl_fall after bit 8 until the scl_fall after the 9th clock. Then:
    - R/W=0 -> PTR;
    - R/W=1 -> RDATA, with MSB of rd_data placed on SDA at that same scl_fall.
  - PTR: shift 8 bits; the pointer takes the low PTR_W bits (upper bits are ignored). Then ACK_PTR, then WDATA.
  - WDATA: shift 8 bits. On the scl_rise of bit 8, wr_data/wr_addr latch the byte/pointer and wr_en=1 for exactly one clk on the next clk. Pointer increments. Then ACK_WDATA, then WDATA again.
  - RDATA: present rd_data bits MSB-first. SDA=0 for a 0 bit; SDA=z for a 1 bit.
    - rd_data is captured into the shift register at the scl_fall starting the byte; later rd_data changes are ignored.
    - After the 8th bit, SDA is released for the master's ACK.
  - RACK: sample SDA on the 9th scl_rise.
    - 0 (ACK): pointer increments; next byte loads on scl_fall; back to RDATA.
    - 1 (NACK): go to IGNORE.
- Pointer wrap: from 2**PTR_W-1 increments to 0. rd_addr always equals the pointer.
- Repeated START after PTR (write-then-read): the pointer is preserved; the read starts at the written pointer.
- General call (addr 0) is not supported: NACKed like any mismatch.
- No clock stretching: SCL is never driven.

Test Plan:
- Write 0xA0 (addr 0x50,W), pointer 0x03, data 0x11, 0x22, STOP -> ACK on all 4 bytes; wr_en pulses with (addr 3, 0x11) then (addr 4, 0x22); busy drops after STOP.
- Address 0x51 write -> 9th-clock SDA high (NACK); no wr_en; SDA stays z through following bytes; busy stays 0.
- Write pointer 0x0E, repeated START, read 0xA1, master ACK, ACK, NACK with bank[14]=0x5A, bank[15]=0xC3, bank[0]=0x7E -> bytes 0x5A, 0xC3, 0x7E on SDA; SDA released after the NACK.
- Pointer 0x0F, write 0x01, 0x02 -> writes at addr 15 then addr 0 (wrap).
- STOP injected mid-byte during WDATA (after 4 bits) -> no wr_en, state IDLE, SDA released. A new START plus a matching address is ACKed normally.
- Reset asserted while driving ACK low -> SDA z and all outputs at reset values on the next clk. Pointer returns to 0.
